// File: rtl/mlp_acc_pkg.sv
// Shared types and constants for the MLP accelerator front end.
// Holds the load sequencer state type, load-type encodings and default frame geometry.
package mlp_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_INPUT  = 2'd1,
        ST_LOAD_WEIGHT = 2'd2,
        ST_WAIT_RESULT = 2'd3
    } load_seq_state_e;

    localparam logic LOAD_TYPE_INPUT  = 1'b1;
    localparam logic LOAD_TYPE_WEIGHT = 1'b0;

    localparam int DEF_DATA_W            = 32;
    localparam int DEF_INPUT_ROWS        = 16;
    localparam int DEF_NUM_LAYERS        = 8;
    localparam int DEF_WEIGHTS_PER_LAYER = 8;
    localparam int DEF_RESULT_COUNT      = 16;

    localparam int IN_IDX_W = 4;
    localparam int LAYER_W  = 3;
    localparam int WGT_W    = 3;

endpackage

// File: rtl/mlp_load_idx_cnt.sv
// Nested layer/weight index counter for the weight phase of a frame.
// Weight index wraps into the layer index; both wrap to 0 after the last word of the frame.
module mlp_load_idx_cnt
    import mlp_acc_pkg::*;
#(
    parameter int NUM_LAYERS        = DEF_NUM_LAYERS,
    parameter int WEIGHTS_PER_LAYER = DEF_WEIGHTS_PER_LAYER
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [LAYER_W-1:0] layer_o,
    output logic [WGT_W-1:0]   weight_o,
    output logic               last_o
);

    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [WGT_W-1:0]   weight_q, weight_d;
    logic               wgt_last;

    assign wgt_last = (weight_q == WGT_W'(WEIGHTS_PER_LAYER - 1));
    assign last_o   = wgt_last && (layer_q == LAYER_W'(NUM_LAYERS - 1));
    assign layer_o  = layer_q;
    assign weight_o = weight_q;

    always_comb begin
        layer_d  = layer_q;
        weight_d = weight_q;
        if (clr_i) begin
            layer_d  = '0;
            weight_d = '0;
        end else if (inc_i) begin
            if (wgt_last) begin
                weight_d = '0;
                layer_d  = last_o ? '0 : layer_q + 1'b1;
            end else begin
                weight_d = weight_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_q  <= '0;
            weight_q <= '0;
        end else begin
            layer_q  <= layer_d;
            weight_q <= weight_d;
        end
    end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Converts a valid/ready word stream into the MLP_acc_top load protocol, one frame per start_i.
// Optional frame XOR checksum output is enabled by defining LOAD_SEQ_CHECKSUM_EN.
module mlp_load_sequencer
    import mlp_acc_pkg::*;
#(
    parameter int DATA_W            = DEF_DATA_W,
    parameter int INPUT_ROWS        = DEF_INPUT_ROWS,
    parameter int NUM_LAYERS        = DEF_NUM_LAYERS,
    parameter int WEIGHTS_PER_LAYER = DEF_WEIGHTS_PER_LAYER,
    parameter int RESULT_COUNT      = DEF_RESULT_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                s_valid_i,
    input  logic [DATA_W-1:0]   s_data_i,
    output logic                s_ready_o,
    output logic                load_en_o,
    output logic [DATA_W-1:0]   load_payload_o,
    output logic                load_type_o,
    output logic [IN_IDX_W-1:0] input_load_number_o,
    output logic [LAYER_W-1:0]  layer_number_o,
    output logic [WGT_W-1:0]    weight_number_o,
    input  logic                result_valid_i,
    output logic                busy_o,
`ifdef LOAD_SEQ_CHECKSUM_EN
    output logic [DATA_W-1:0]   checksum_o,
`endif
    output logic                frame_done_o
);

    localparam int RC_W = $clog2(RESULT_COUNT + 1);

    load_seq_state_e     state_q, state_d;
    logic [IN_IDX_W-1:0] in_row_q, in_row_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic                xfer, in_last, start_acc, frame_done;
    logic [LAYER_W-1:0]  cnt_layer;
    logic [WGT_W-1:0]    cnt_wgt;
    logic                cnt_last;

    logic                load_en_q, load_type_q;
    logic [DATA_W-1:0]   payload_q;
    logic [IN_IDX_W-1:0] in_num_q;
    logic [LAYER_W-1:0]  layer_num_q;
    logic [WGT_W-1:0]    wgt_num_q;

    assign s_ready_o = (state_q == ST_LOAD_INPUT) || (state_q == ST_LOAD_WEIGHT);
    assign xfer      = s_valid_i && s_ready_o;
    assign in_last   = (in_row_q == IN_IDX_W'(INPUT_ROWS - 1));

    mlp_load_idx_cnt #(
        .NUM_LAYERS        (NUM_LAYERS),
        .WEIGHTS_PER_LAYER (WEIGHTS_PER_LAYER)
    ) u_idx_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_acc),
        .inc_i    (xfer && (state_q == ST_LOAD_WEIGHT)),
        .layer_o  (cnt_layer),
        .weight_o (cnt_wgt),
        .last_o   (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        in_row_d   = in_row_q;
        rcnt_d     = rcnt_q;
        frame_done = 1'b0;
        start_acc  = 1'b0;
        // Results may overtake the loads, so count from the first load state and saturate.
        if (state_q != ST_IDLE && result_valid_i && rcnt_q != RC_W'(RESULT_COUNT))
            rcnt_d = rcnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = ST_LOAD_INPUT;
                    in_row_d  = '0;
                    rcnt_d    = '0;
                end
            end
            ST_LOAD_INPUT: begin
                if (xfer) begin
                    in_row_d = in_last ? '0 : in_row_q + 1'b1;
                    if (in_last) state_d = ST_LOAD_WEIGHT;
                end
            end
            ST_LOAD_WEIGHT: begin
                if (xfer && cnt_last) state_d = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                // Done is flagged in the cycle the final pulse arrives, not after it registers.
                if (rcnt_d == RC_W'(RESULT_COUNT)) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                    rcnt_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            in_row_q <= '0;
            rcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_row_q <= in_row_d;
            rcnt_q   <= rcnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_en_q   <= 1'b0;
            payload_q   <= '0;
            load_type_q <= 1'b0;
            in_num_q    <= '0;
            layer_num_q <= '0;
            wgt_num_q   <= '0;
        end else begin
            load_en_q <= xfer;
            if (xfer) begin
                payload_q <= s_data_i;
                if (state_q == ST_LOAD_INPUT) begin
                    load_type_q <= LOAD_TYPE_INPUT;
                    in_num_q    <= in_row_q;
                    layer_num_q <= '0;
                    wgt_num_q   <= '0;
                end else begin
                    load_type_q <= LOAD_TYPE_WEIGHT;
                    in_num_q    <= '0;
                    layer_num_q <= cnt_layer;
                    wgt_num_q   <= cnt_wgt;
                end
            end
        end
    end

`ifdef LOAD_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            csum_q <= '0;
        else if (start_acc) csum_q <= '0;
        else if (xfer)      csum_q <= csum_q ^ s_data_i;
    end

    assign checksum_o = csum_q;
`endif

    assign load_en_o           = load_en_q;
    assign load_payload_o      = payload_q;
    assign load_type_o         = load_type_q;
    assign input_load_number_o = in_num_q;
    assign layer_number_o      = layer_num_q;
    assign weight_number_o     = wgt_num_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign frame_done_o        = frame_done;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Self-checking bench for mlp_load_sequencer: short vector table plus model-checked frames.
// Define LOAD_SEQ_CHECKSUM_EN to also check checksum_o.
module tb_mlp_load_sequencer;
    import mlp_acc_pkg::*;

    localparam int DW = 32;
    localparam int NIN = 16;
    localparam int NW = 80;
    localparam int RC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i, s_valid_i, result_valid_i;
    logic [DW-1:0]   s_data_i;
    logic            s_ready_o, load_en_o, load_type_o, busy_o, frame_done_o;
    logic [DW-1:0]   load_payload_o;
    logic [3:0]      input_load_number_o;
    logic [2:0]      layer_number_o, weight_number_o;
`ifdef LOAD_SEQ_CHECKSUM_EN
    logic [DW-1:0]   checksum_o;
`endif

    always #5 clk = ~clk;

    mlp_load_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .s_valid_i           (s_valid_i),
        .s_data_i            (s_data_i),
        .s_ready_o           (s_ready_o),
        .load_en_o           (load_en_o),
        .load_payload_o      (load_payload_o),
        .load_type_o         (load_type_o),
        .input_load_number_o (input_load_number_o),
        .layer_number_o      (layer_number_o),
        .weight_number_o     (weight_number_o),
        .result_valid_i      (result_valid_i),
        .busy_o              (busy_o),
`ifdef LOAD_SEQ_CHECKSUM_EN
        .checksum_o          (checksum_o),
`endif
        .frame_done_o        (frame_done_o)
    );

    int n_pass = 0;
    int n_total = 0;

    // Frame-level reference: busy flag, words accepted, results seen, running XOR.
    bit          m_busy;
    int          m_words;
    int          m_results;
    logic [31:0] m_csum;

    typedef struct {
        logic        st;
        logic        vld;
        logic [31:0] dat;
        logic        exp_busy;
        logic        exp_ready;
        logic        exp_load;
        logic [31:0] exp_row;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        m_busy = 0;
        m_words = 0;
        m_results = 0;
        m_csum = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_i = 1'b0;
        s_valid_i = 1'b0;
        result_valid_i = 1'b0;
        s_data_i = '0;
        #1;
        chk("rst_load_en", 32'(load_en_o), 32'd0);
        chk("rst_payload", load_payload_o, 32'd0);
        chk("rst_type", 32'(load_type_o), 32'd0);
        chk("rst_row", 32'(input_load_number_o), 32'd0);
        chk("rst_layer", 32'(layer_number_o), 32'd0);
        chk("rst_weight", 32'(weight_number_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(s_ready_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
`ifdef LOAD_SEQ_CHECKSUM_EN
        chk("rst_checksum", checksum_o, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, step the model, check the registered load.
    task automatic cycle(input logic st, input logic vld, input logic [31:0] dat, input logic rv);
        logic exp_ready, exp_done, xfer;
        int   k, res_after;
        start_i = st;
        s_valid_i = vld;
        s_data_i = dat;
        result_valid_i = rv;
        #1;
        exp_ready = m_busy && (m_words < NW);
        res_after = m_results + ((m_busy && rv) ? 1 : 0);
        if (res_after > RC) res_after = RC;
        exp_done = m_busy && (m_words == NW) && (res_after == RC);
        chk("s_ready", 32'(s_ready_o), 32'(exp_ready));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("frame_done", 32'(frame_done_o), 32'(exp_done));
`ifdef LOAD_SEQ_CHECKSUM_EN
        if (exp_done) chk("checksum", checksum_o, m_csum);
`endif
        xfer = vld && exp_ready;
        k = m_words;
        if (m_busy) m_results = res_after;
        if (xfer) begin
            m_words++;
            m_csum ^= dat;
        end
        if (exp_done) model_clear();
        else if (!m_busy && st) begin
            m_busy = 1;
            m_words = 0;
            m_results = 0;
            m_csum = '0;
        end
        @(posedge clk);
        #1;
        chk("load_en", 32'(load_en_o), 32'(xfer));
        if (xfer) begin
            chk("payload", load_payload_o, dat);
            chk("load_type", 32'(load_type_o), (k < NIN) ? 32'd1 : 32'd0);
            chk("row", 32'(input_load_number_o), (k < NIN) ? 32'(k) : 32'd0);
            chk("layer", 32'(layer_number_o), (k < NIN) ? 32'd0 : 32'((k - NIN) / 8));
            chk("weight", 32'(weight_number_o), (k < NIN) ? 32'd0 : 32'((k - NIN) % 8));
        end
    endtask

    // vmode: 0 back-to-back, 1 every other cycle, 2 random.
    // rmode: 0 results after loads, 1 results during first weights, 2 random.
    task automatic run_frame(input int vmode, input int rmode, input int start_at,
                             input int rst_at, input string tag);
        int          cyc;
        bit          start_sent;
        logic        v, rv, st;
        logic [31:0] d;
        cyc = 0;
        start_sent = 0;
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        while (m_busy && cyc < 3000) begin
            if (rst_at >= 0 && m_words == rst_at) begin
                do_reset();
                $display("frame %s: reset after %0d words", tag, rst_at);
                return;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            d = (vmode == 2) ? $urandom : 32'(m_words);
            case (rmode)
                0:       rv = (m_words == NW);
                1:       rv = (m_words >= NIN) && (m_words < NIN + RC);
                default: rv = ($urandom_range(0, 3) == 0);
            endcase
            st = 1'b0;
            if (start_at >= 0 && m_words == start_at && !start_sent) begin
                st = 1'b1;
                start_sent = 1;
            end
            if (vmode == 2 && $urandom_range(0, 15) == 0) st = 1'b1;
            cycle(st, v, d, rv);
            cyc++;
        end
        if (m_busy) chk("frame_timeout", 32'(cyc), 32'd0);
        $display("frame %s: completed in %0d cycles", tag, cyc);
    endtask

    initial begin
        tbl[0] = '{st: 1'b0, vld: 1'b1, dat: 32'h11, exp_busy: 1'b0, exp_ready: 1'b0, exp_load: 1'b0, exp_row: 32'd0};
        tbl[1] = '{st: 1'b1, vld: 1'b0, dat: 32'h00, exp_busy: 1'b0, exp_ready: 1'b0, exp_load: 1'b0, exp_row: 32'd0};
        tbl[2] = '{st: 1'b0, vld: 1'b1, dat: 32'hA5, exp_busy: 1'b1, exp_ready: 1'b1, exp_load: 1'b1, exp_row: 32'd0};
        tbl[3] = '{st: 1'b0, vld: 1'b0, dat: 32'h00, exp_busy: 1'b1, exp_ready: 1'b1, exp_load: 1'b0, exp_row: 32'd0};
        tbl[4] = '{st: 1'b1, vld: 1'b1, dat: 32'h5A, exp_busy: 1'b1, exp_ready: 1'b1, exp_load: 1'b1, exp_row: 32'd1};
        tbl[5] = '{st: 1'b0, vld: 1'b0, dat: 32'h00, exp_busy: 1'b1, exp_ready: 1'b1, exp_load: 1'b0, exp_row: 32'd1};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            start_i = tbl[i].st;
            s_valid_i = tbl[i].vld;
            s_data_i = tbl[i].dat;
            result_valid_i = 1'b0;
            #1;
            chk("vec_busy", 32'(busy_o), 32'(tbl[i].exp_busy));
            chk("vec_ready", 32'(s_ready_o), 32'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            chk("vec_load_en", 32'(load_en_o), 32'(tbl[i].exp_load));
            if (tbl[i].exp_load) begin
                chk("vec_row", 32'(input_load_number_o), tbl[i].exp_row);
                chk("vec_payload", load_payload_o, tbl[i].dat);
            end
            $display("vector %0d: start=%0b valid=%0b load_en=%0b", i, tbl[i].st, tbl[i].vld, load_en_o);
        end
        do_reset();

        run_frame(0, 0, -1, -1, "back_to_back");
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        run_frame(1, 0, -1, -1, "toggle_valid");
        run_frame(0, 1, -1, -1, "early_results");
        run_frame(1, 1, -1, -1, "toggle_early_results");
        run_frame(0, 0, 40, 50, "start_then_reset");
        run_frame(0, 0, -1, -1, "after_reset");
        for (int f = 0; f < 6; f++) begin
            run_frame(2, 2, -1, -1, "random");
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
